game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game-flow controller for the VGA shooter. It sits between the frame-tick generator and the sprite modules (paddle, bullet, enemy array, bouncing ball), and decides when sprites may move and when they are re-initialised. It also tracks remaining lives and the current level. Its state drives the banner and score display logic.

## Interface
Parameters:
- LIVES, 3: lives granted at game start (1..15)
- PAUSE_FRAMES, 60: frames frozen after a hit or a wave clear (1..255)
- NUM_ENE, 12: number of enemy sprites
- MAX_LEVEL, 7: level saturation value (≤7)

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  asynchronous, active-high reset
- pixpulse  in  1  25 MHz pixel enable, one clk wide every 4 clks
- frame  in  1  start-of-vblank tick; held high until the next pixpulse, so 1–4 clks wide
- start  in  1  start button, already synchronised and debounced
- player_hit  in  1  paddle-hit event, one clk pulse
- broken  in  NUM_ENE  per-enemy destroyed flags
- move_out  out  1  gated frame tick to the sprites
- sprite_rst  out  1  sprite re-initialise
- state  out  3  IDLE=0, PLAY=1, HIT=2, CLEAR=3, OVER=4
- lives  out  4  remaining lives
- level  out  3  current level, starts at 0

## Operation
- Start edge detection: start_rise = start & ~start_d. start_d is registered every clk, not only on pixpulse.
- Frame count event: fcount_ev = frame & pixpulse. This gives exactly one event per frame.
- IDLE:
  - sprite_rst=1, move_out=0.
  - On start_rise: lives←LIVES, level←0, go to PLAY.
- PLAY:
  - move_out = frame.
  - player_hit: lives←lives−1. If lives was 1 → OVER, else → HIT. Clear the frame counter.
  - Otherwise, if &broken: → CLEAR and clear the frame counter.
  - player_hit and &broken in the same cycle: the hit wins.
- HIT:
  - move_out=0. Sprites freeze; broken state is kept.
  - Counter increments on fcount_ev. When it reaches PAUSE_FRAMES → PLAY.
  - player_hit is ignored.
- CLEAR:
  - move_out=0. Counter runs as in HIT.
  - At PAUSE_FRAMES: level←min(level+1, MAX_LEVEL), → PLAY, and a one-clk sprite_rst pulse fires.
- OVER:
  - move_out=0. lives reads 0. All inputs except start are ignored.
  - On start_rise → IDLE. A second start_rise is then needed to begin play.
- Widths:
  - Frame counter is 8 bits and is compared for equality with PAUSE_FRAMES.
  - lives is never decremented below 0.
  - level never wraps.
- Undefined state encodings (5–7) go to IDLE on the next clk.

## Timing
- Reset values: state=IDLE, lives=0, level=0, frame counter=0, start_d=0, sprite_rst=1, move_out=0.
- move_out is combinational: frame & (state==PLAY). Zero latency, no extra registers. It follows frame for all of its 1–4 clk width.
- State, lives and level update on the clk edge after the causing input. Outputs derived from state change in that same cycle.
- sprite_rst:
  - Level-high for the whole time in IDLE.
  - Exactly one clk high on the CLEAR→PLAY transition, coincident with the first PLAY cycle.
  - Not asserted on HIT→PLAY.
- Pause length: PLAY resumes on the clk after the PAUSE_FRAMES-th fcount_ev following entry to HIT or CLEAR.
- A fcount_ev in the same cycle as the entering transition is not counted.
- rst asserted mid-operation returns to IDLE immediately, with all reset values, regardless of state or counter.

## Test plan
- Game start: rst, then start held 10 clks → exactly one IDLE→PLAY transition; lives=3, level=0, sprite_rst drops to 0 in PLAY; move_out mirrors frame.
- Hit recovery: in PLAY pulse player_hit → state=HIT, lives=2, move_out stays 0 across frames; after 60 fcount_ev → PLAY with no sprite_rst pulse.
- Game over: three hits each followed by recovery → after the third hit state=OVER, lives=0; start_rise → IDLE; another start_rise → PLAY, lives=3.
- Wave clear: drive broken=12'hfff in PLAY → CLEAR; after 60 frames level=1, one-clk sprite_rst pulse, state=PLAY. Repeat 9 times → level saturates at 7.
- Simultaneous events: player_hit and broken=12'hfff in the same clk with lives=1 → OVER, level unchanged. With lives=2 → HIT.
- Mid-operation reset: assert rst during CLEAR at frame count 30 → state=IDLE, counter=0, level=0, sprite_rst=1 within the same clk.

Source files
------------

// File: rtl/game_sequencer.sv
// Game-flow controller for the VGA shooter: gates sprite motion, re-initialises
// sprites, and tracks lives and level across play, hit pauses and wave clears.
module game_sequencer #(
  parameter int LIVES        = 3,
  parameter int PAUSE_FRAMES = 60,
  parameter int NUM_ENE      = 12,
  parameter int MAX_LEVEL    = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixpulse,
  input  logic               frame,
  input  logic               start,
  input  logic               player_hit,
  input  logic [NUM_ENE-1:0] broken,
  output logic               move_out,
  output logic               sprite_rst,
  output logic [2:0]         state,
  output logic [3:0]         lives,
  output logic [2:0]         level
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_HIT   = 3'd2,
    S_CLEAR = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_lives;
  logic [2:0]  r_level;
  logic [7:0]  r_cnt;
  logic        r_start_d;
  logic        r_sprite_rst;

  logic        w_start_rise;
  logic        w_fev;
  logic [7:0]  w_cnt_inc;
  logic        w_pause_done;

  assign w_start_rise = start & ~r_start_d;
  // frame spans exactly one pixpulse, so this fires once per frame
  assign w_fev        = frame & pixpulse;
  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_pause_done = w_fev && (w_cnt_inc == 8'(PAUSE_FRAMES));

  assign move_out   = frame & (r_state == S_PLAY);
  assign sprite_rst = r_sprite_rst;
  assign state      = r_state;
  assign lives      = r_lives;
  assign level      = r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lives      <= 4'd0;
      r_level      <= 3'd0;
      r_cnt        <= 8'd0;
      r_start_d    <= 1'b0;
      r_sprite_rst <= 1'b1;
    end else begin
      r_start_d <= start;
      case (r_state)
        S_IDLE: begin
          r_sprite_rst <= 1'b1;
          if (w_start_rise) begin
            r_lives      <= 4'(LIVES);
            r_level      <= 3'd0;
            r_sprite_rst <= 1'b0;
            r_state      <= S_PLAY;
          end
        end
        S_PLAY: begin
          r_sprite_rst <= 1'b0;
          if (player_hit) begin
            if (r_lives != 4'd0) r_lives <= r_lives - 4'd1;
            r_cnt   <= 8'd0;
            r_state <= (r_lives <= 4'd1) ? S_OVER : S_HIT;
          end else if (&broken) begin
            r_cnt   <= 8'd0;
            r_state <= S_CLEAR;
          end
        end
        S_HIT: begin
          r_sprite_rst <= 1'b0;
          if (w_fev) r_cnt <= w_cnt_inc;
          if (w_pause_done) r_state <= S_PLAY;
        end
        S_CLEAR: begin
          r_sprite_rst <= 1'b0;
          if (w_fev) r_cnt <= w_cnt_inc;
          // one-clk re-init pulse lands on the first PLAY cycle
          if (w_pause_done) begin
            if (r_level < 3'(MAX_LEVEL)) r_level <= r_level + 3'd1;
            r_sprite_rst <= 1'b1;
            r_state      <= S_PLAY;
          end
        end
        S_OVER: begin
          r_sprite_rst <= 1'b0;
          if (w_start_rise) begin
            r_sprite_rst <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_sprite_rst <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: start, hit pauses, game over,
// wave clears with level saturation, simultaneous events, mid-run reset.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pixpulse;
  logic        frame;
  logic        start;
  logic        player_hit;
  logic [11:0] broken;
  logic        move_out;
  logic        sprite_rst;
  logic [2:0]  state;
  logic [3:0]  lives;
  logic [2:0]  level;

  int checks = 0;
  int failures = 0;
  int ph = 0;

  localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, HIT = 3'd2;
  localparam logic [2:0] CLEAR = 3'd3, OVER = 3'd4;

  game_sequencer dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .frame(frame),
    .start(start), .player_hit(player_hit), .broken(broken),
    .move_out(move_out), .sprite_rst(sprite_rst), .state(state),
    .lives(lives), .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    pixpulse = (ph == 3);
  endtask

  // one frame tick: frame held until and through one pixpulse cycle
  task automatic one_frame();
    frame = 1'b1;
    while (!pixpulse) step();
    step();
    frame = 1'b0;
    step();
  endtask

  // raise frame and stop just after the edge that sees the fcount event
  task automatic frame_edge();
    frame = 1'b1;
    while (!pixpulse) step();
    step();
  endtask

  task automatic press_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; frame = 1'b1;
    step(); step();
    checks++;
    if (state !== IDLE || lives !== 4'd0 || level !== 3'd0 ||
        sprite_rst !== 1'b1 || move_out !== 1'b0) begin
      failures++;
      $display("FAIL reset: st=%0d lv=%0d lvl=%0d sr=%b mo=%b want 0 0 0 1 0",
               state, lives, level, sprite_rst, move_out);
    end
    frame = 1'b0;
    rst = 1'b0;
    step(); step();
    checks++;
    if (state !== IDLE || sprite_rst !== 1'b1) begin
      failures++;
      $display("FAIL idle_hold: st=%0d sr=%b want 0 1", state, sprite_rst);
    end
  endtask

  task automatic test_start();
    int ent = 0;
    logic [2:0] prev;
    prev = state;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (prev != PLAY && state == PLAY) ent++;
      prev = state;
    end
    start = 1'b0;
    step();
    checks++;
    if (ent !== 1 || state !== PLAY) begin
      failures++;
      $display("FAIL start_once: entries=%0d st=%0d want 1 1", ent, state);
    end
    checks++;
    if (lives !== 4'd3 || level !== 3'd0 || sprite_rst !== 1'b0) begin
      failures++;
      $display("FAIL start_vals: lv=%0d lvl=%0d sr=%b want 3 0 0",
               lives, level, sprite_rst);
    end
    frame = 1'b1; #1;
    checks++;
    if (move_out !== 1'b1) begin
      failures++;
      $display("FAIL move_hi: got %b want 1", move_out);
    end
    frame = 1'b0; #1;
    checks++;
    if (move_out !== 1'b0) begin
      failures++;
      $display("FAIL move_lo: got %b want 0", move_out);
    end
  endtask

  // hit lands on a cycle with an fcount event, which must not be counted
  task automatic test_hit_recovery();
    int bad_mo = 0;
    while (!pixpulse) step();
    frame = 1'b1; player_hit = 1'b1;
    step();
    frame = 1'b0; player_hit = 1'b0;
    step();
    checks++;
    if (state !== HIT || lives !== 4'd2) begin
      failures++;
      $display("FAIL hit_enter: st=%0d lv=%0d want 2 2", state, lives);
    end
    player_hit = 1'b1; step(); player_hit = 1'b0; step();
    checks++;
    if (lives !== 4'd2 || state !== HIT) begin
      failures++;
      $display("FAIL hit_ignored: st=%0d lv=%0d want 2 2", state, lives);
    end
    for (int i = 0; i < 59; i++) begin
      frame = 1'b1; #1;
      if (move_out !== 1'b0) bad_mo++;
      one_frame();
    end
    checks++;
    if (state !== HIT || bad_mo !== 0) begin
      failures++;
      $display("FAIL hit_59: st=%0d move_leaks=%0d want 2 0", state, bad_mo);
    end
    frame_edge();
    checks++;
    if (state !== PLAY || sprite_rst !== 1'b0) begin
      failures++;
      $display("FAIL hit_resume: st=%0d sr=%b want 1 0", state, sprite_rst);
    end
    frame = 1'b0; step();
  endtask

  task automatic hit_and_recover();
    player_hit = 1'b1; step(); player_hit = 1'b0;
    repeat (60) one_frame();
  endtask

  task automatic test_game_over();
    hit_and_recover();
    checks++;
    if (state !== PLAY || lives !== 4'd1) begin
      failures++;
      $display("FAIL second_hit: st=%0d lv=%0d want 1 1", state, lives);
    end
    player_hit = 1'b1; step(); player_hit = 1'b0;
    frame = 1'b1; #1;
    checks++;
    if (state !== OVER || lives !== 4'd0 || move_out !== 1'b0) begin
      failures++;
      $display("FAIL over: st=%0d lv=%0d mo=%b want 4 0 0",
               state, lives, move_out);
    end
    frame = 1'b0;
    player_hit = 1'b1; broken = 12'hfff; step();
    player_hit = 1'b0; broken = 12'h000; step();
    press_start();
    checks++;
    if (state !== IDLE || sprite_rst !== 1'b1 || lives !== 4'd0) begin
      failures++;
      $display("FAIL over_idle: st=%0d sr=%b lv=%0d want 0 1 0",
               state, sprite_rst, lives);
    end
    press_start();
    checks++;
    if (state !== PLAY || lives !== 4'd3 || level !== 3'd0) begin
      failures++;
      $display("FAIL restart: st=%0d lv=%0d lvl=%0d want 1 3 0",
               state, lives, level);
    end
  endtask

  task automatic clear_wave(input logic [2:0] exp_lvl);
    broken = 12'hfff; step(); broken = 12'h000;
    checks++;
    if (state !== CLEAR) begin
      failures++;
      $display("FAIL clear_enter: st=%0d want 3", state);
    end
    repeat (59) one_frame();
    checks++;
    if (state !== CLEAR || sprite_rst !== 1'b0) begin
      failures++;
      $display("FAIL clear_59: st=%0d sr=%b want 3 0", state, sprite_rst);
    end
    frame_edge();
    checks++;
    if (state !== PLAY || sprite_rst !== 1'b1 || level !== exp_lvl) begin
      failures++;
      $display("FAIL clear_done: st=%0d sr=%b lvl=%0d want 1 1 %0d",
               state, sprite_rst, level, exp_lvl);
    end
    frame = 1'b0; step();
    checks++;
    if (sprite_rst !== 1'b0) begin
      failures++;
      $display("FAIL clear_pulse_len: sr=%b want 0", sprite_rst);
    end
  endtask

  task automatic test_wave_clear();
    for (int i = 1; i <= 9; i++)
      clear_wave((i > 7) ? 3'd7 : 3'(i));
  endtask

  task automatic test_simultaneous();
    player_hit = 1'b1; broken = 12'hfff; step();
    player_hit = 1'b0; broken = 12'h000;
    checks++;
    if (state !== HIT || lives !== 4'd2 || level !== 3'd7) begin
      failures++;
      $display("FAIL simul_l3: st=%0d lv=%0d lvl=%0d want 2 2 7",
               state, lives, level);
    end
    repeat (60) one_frame();
    player_hit = 1'b1; broken = 12'hfff; step();
    player_hit = 1'b0; broken = 12'h000;
    checks++;
    if (state !== HIT || lives !== 4'd1) begin
      failures++;
      $display("FAIL simul_l2: st=%0d lv=%0d want 2 1", state, lives);
    end
    repeat (60) one_frame();
    player_hit = 1'b1; broken = 12'hfff; step();
    player_hit = 1'b0; broken = 12'h000;
    checks++;
    if (state !== OVER || lives !== 4'd0 || level !== 3'd7) begin
      failures++;
      $display("FAIL simul_l1: st=%0d lv=%0d lvl=%0d want 4 0 7",
               state, lives, level);
    end
  endtask

  task automatic test_mid_reset();
    press_start();
    press_start();
    clear_wave(3'd1);
    broken = 12'hfff; step(); broken = 12'h000;
    repeat (30) one_frame();
    rst = 1'b1; #1;
    checks++;
    if (state !== IDLE || level !== 3'd0 || lives !== 4'd0 ||
        sprite_rst !== 1'b1) begin
      failures++;
      $display("FAIL mid_rst: st=%0d lvl=%0d lv=%0d sr=%b want 0 0 0 1",
               state, level, lives, sprite_rst);
    end
    step();
    rst = 1'b0;
    step();
    press_start();
    clear_wave(3'd1);
  endtask

  initial begin
    rst = 1'b1; pixpulse = 1'b0; frame = 1'b0; start = 1'b0;
    player_hit = 1'b0; broken = 12'h000;
    test_reset();
    test_start();
    test_hit_recovery();
    test_game_over();
    test_wave_clear();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
